// File: rtl/signal_pkg.sv
// Shared definitions for the signal processor run controller.
// State encoding, opcode constants and the CRT pixel rule.
package signal_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_DONE,
    S_ERR
  } run_state_e;

  localparam logic [1:0] OP_NOOP = 2'd0;
  localparam logic [1:0] OP_ADDX = 2'd1;
  localparam logic [1:0] OP_TERM = 2'd2;

  localparam int DEF_ROW_WIDTH = 40;

  // Sprite is three pixels wide, centred on X.
  function automatic logic pixel_lit(
    input logic [15:0] x,
    input logic [15:0] col
  );
    logic signed [16:0] xs;
    logic signed [16:0] cs;
    xs = {x[15], x};
    cs = {1'b0, col};
    return (xs - 17'sd1 <= cs) && (cs <= xs + 17'sd1);
  endfunction

endpackage

// File: rtl/crt_row_buffer.sv
// CRT row builder: column counter, pixel shift register and
// a valid/ready row output register with core stall request.
module crt_row_buffer
  import signal_pkg::*;
#(
  parameter int ROW_WIDTH = DEF_ROW_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 run_i,
  input  logic                 pix_en_i,
  input  logic                 term_step_i,
  input  logic                 flush_i,
  input  logic                 discard_i,
  input  logic [15:0]          x_i,
  input  logic                 row_ready_i,
  output logic                 stall_o,
  output logic                 col_zero_o,
  output logic                 final_acc_o,
  output logic                 row_valid_o,
  output logic [ROW_WIDTH-1:0] row_data_o,
  output logic                 row_last_o
);

  localparam int CW = $clog2(ROW_WIDTH);
  localparam logic [CW-1:0] LAST_COL = CW'(ROW_WIDTH - 1);
  localparam logic [CW:0] WIDTH_V = (CW + 1)'(ROW_WIDTH);

  logic [CW-1:0]        col_q, col_d;
  logic [ROW_WIDTH-1:0] sh_q, sh_d;
  logic [ROW_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;

  logic                 lit;
  logic                 at_last;
  logic                 accept;
  logic                 free;
  logic                 load_full;
  logic                 load_part;
  logic                 mark_last;
  logic [CW:0]          shamt;
  logic [ROW_WIDTH-1:0] full_row;

  assign lit       = pixel_lit(x_i, 16'(col_q));
  assign at_last   = (col_q == LAST_COL);
  assign accept    = valid_q & row_ready_i;
  assign free      = ~valid_q | row_ready_i;
  assign load_full = pix_en_i & at_last;
  assign load_part = flush_i & (col_q != '0) & free;
  // A pending full row at TERM time is the final row of the run.
  assign mark_last = term_step_i & (col_q == '0) & valid_q;
  assign shamt     = WIDTH_V - {1'b0, col_q};
  assign full_row  = {sh_q[ROW_WIDTH-2:0], lit};

  assign stall_o     = run_i & at_last & valid_q & ~row_ready_i;
  assign col_zero_o  = (col_q == '0);
  assign row_last_o  = last_q | mark_last;
  assign final_acc_o = accept & row_last_o;
  assign row_valid_o = valid_q;
  assign row_data_o  = data_q;

  always_comb begin
    col_d   = col_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (mark_last && !row_ready_i) last_d = 1'b1;
    if (pix_en_i) begin
      sh_d  = full_row;
      col_d = at_last ? '0 : col_q + CW'(1);
    end
    if (load_full) begin
      valid_d = 1'b1;
      last_d  = 1'b0;
      data_d  = full_row;
    end
    if (load_part) begin
      valid_d = 1'b1;
      last_d  = 1'b1;
      data_d  = sh_q << shamt;
      col_d   = '0;
      sh_d    = '0;
    end
    if (discard_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (clear_i) begin
      col_d   = '0;
      sh_d    = '0;
      data_d  = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/signal_run_ctrl.sv
// Run controller: resets and single-steps the signal core,
// sums sampled signal strength and streams CRT rows.
module signal_run_ctrl
  import signal_pkg::*;
#(
  parameter int          FIRST_SAMPLE = 20,
  parameter int          SAMPLE_STEP  = 40,
  parameter int          NUM_SAMPLES  = 6,
  parameter int          ROW_WIDTH    = DEF_ROW_WIDTH,
  parameter logic [15:0] MAX_CYCLES   = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 proc_reset,
  output logic                 cpu_en,
  input  logic [15:0]          cycles_in,
  input  logic [15:0]          x_in,
  input  logic                 term_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 incomplete,
  output logic [31:0]          sum_out,
  output logic [2:0]           samples_taken,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [ROW_WIDTH-1:0] row_data,
  output logic                 row_last
);

  localparam logic [15:0] FIRST_V = 16'(FIRST_SAMPLE);
  localparam logic [15:0] STEP_V  = 16'(SAMPLE_STEP);
  localparam logic [2:0]  NUM_V   = 3'(NUM_SAMPLES);

  run_state_e  state_q, state_d;
  logic [31:0] sum_q, sum_d;
  logic [2:0]  samp_q, samp_d;
  logic [15:0] next_q, next_d;
  logic        inc_q, inc_d;

  logic        stall;
  logic        col_zero;
  logic        final_acc;
  logic        step;
  logic        term_step;
  logic        max_step;
  logic        pix_en;
  logic        hit;
  logic [31:0] prod;

  assign cpu_en    = (state_q == S_RUN) & ~stall;
  assign step      = cpu_en;
  assign term_step = step & term_in;
  assign max_step  = step & ~term_in & (cycles_in == MAX_CYCLES);
  assign pix_en    = step & ~term_in & ~max_step;
  assign hit       = step & ~term_in & (samp_q < NUM_V)
                   & (cycles_in == next_q);
  // Low 32 bits of the product are the same signed or unsigned.
  assign prod      = {{16{x_in[15]}}, x_in} * {16'b0, cycles_in};

  assign proc_reset    = (state_q == S_IDLE) | (state_q == S_CLEAR);
  assign busy          = (state_q == S_CLEAR) | (state_q == S_RUN)
                       | (state_q == S_FLUSH);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign incomplete    = inc_q;
  assign sum_out       = sum_q;
  assign samples_taken = samp_q;

  crt_row_buffer #(
    .ROW_WIDTH(ROW_WIDTH)
  ) u_row (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (state_q == S_CLEAR),
    .run_i      (state_q == S_RUN),
    .pix_en_i   (pix_en),
    .term_step_i(term_step),
    .flush_i    (state_q == S_FLUSH),
    .discard_i  (max_step),
    .x_i        (x_in),
    .row_ready_i(row_ready),
    .stall_o    (stall),
    .col_zero_o (col_zero),
    .final_acc_o(final_acc),
    .row_valid_o(row_valid),
    .row_data_o (row_data),
    .row_last_o (row_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (term_step) begin
          state_d = (!col_zero || (row_valid && !final_acc))
                  ? S_FLUSH : S_DONE;
        end else if (max_step) begin
          state_d = S_ERR;
        end
      end
      S_FLUSH: if (final_acc) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum_d  = sum_q;
    samp_d = samp_q;
    next_d = next_q;
    inc_d  = inc_q;
    if (state_q == S_CLEAR) begin
      sum_d  = '0;
      samp_d = '0;
      next_d = FIRST_V;
      inc_d  = 1'b0;
    end else begin
      if (hit) begin
        sum_d  = sum_q + prod;
        samp_d = samp_q + 3'd1;
        next_d = next_q + STEP_V;
      end
      if (term_step && samp_q < NUM_V) inc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      samp_q  <= '0;
      next_q  <= FIRST_V;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      samp_q  <= samp_d;
      next_q  <= next_d;
      inc_q   <= inc_d;
    end
  end

endmodule

// File: tb/tb_signal_run_ctrl.sv
// Bench for signal_run_ctrl: emulated core plus a
// trace-level reference model of samples and CRT rows.
module tb_signal_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic        proc_reset, cpu_en, term_in;
  logic [15:0] cycles_in, x_in;
  logic        busy, done, err, incomplete;
  logic [31:0] sum_out;
  logic [2:0]  samples_taken;
  logic        row_valid, row_ready, row_last;
  logic [39:0] row_data;

  logic        start_b, proc_reset_b, cpu_en_b;
  logic        busy_b, done_b, err_b, inc_b;
  logic [31:0] sum_b;
  logic [2:0]  samp_b;
  logic        rv_b, rl_b;
  logic [39:0] rd_b;
  logic [15:0] cyc_b;
  logic [15:0] last_b;

  int passed = 0;
  int total  = 0;

  signal_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .proc_reset(proc_reset), .cpu_en(cpu_en),
    .cycles_in(cycles_in), .x_in(x_in), .term_in(term_in),
    .busy(busy), .done(done), .err(err), .incomplete(incomplete),
    .sum_out(sum_out), .samples_taken(samples_taken),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_last(row_last)
  );

  signal_run_ctrl #(.MAX_CYCLES(16'd100)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .proc_reset(proc_reset_b), .cpu_en(cpu_en_b),
    .cycles_in(cyc_b), .x_in(16'd1), .term_in(1'b0),
    .busy(busy_b), .done(done_b), .err(err_b), .incomplete(inc_b),
    .sum_out(sum_b), .samples_taken(samp_b),
    .row_valid(rv_b), .row_ready(1'b1),
    .row_data(rd_b), .row_last(rl_b)
  );

  // Emulated core: program entry 0 = noop, else addx <value>.
  int          prog[$];
  int          std_prog[$];
  logic [15:0] cyc, xr;
  int          pc;
  bit          sub;

  assign cycles_in = cyc;
  assign x_in      = xr;
  assign term_in   = (pc >= prog.size());

  always @(posedge clk) begin
    if (proc_reset) begin
      cyc <= 16'd1; xr <= 16'd1; pc <= 0; sub <= 1'b0;
    end else if (cpu_en) begin
      cyc <= cyc + 16'd1;
      if (pc < prog.size()) begin
        if (prog[pc] == 0) pc <= pc + 1;
        else if (!sub) sub <= 1'b1;
        else begin
          xr  <= xr + 16'(prog[pc]);
          pc  <= pc + 1;
          sub <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (proc_reset_b) cyc_b <= 16'd1;
    else if (cpu_en_b) cyc_b <= cyc_b + 16'd1;
  end
  always @(negedge clk) if (cpu_en_b) last_b <= cyc_b;

  logic [39:0] rows_q[$];
  bit          lasts_q[$];
  always @(negedge clk) begin
    if (row_valid && row_ready) begin
      rows_q.push_back(row_data);
      lasts_q.push_back(row_last);
    end
  end

  // 0: always ready, 1: random, 2: held low
  int rr_mode = 0;
  initial begin
    row_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rr_mode == 0) row_ready = 1'b1;
      else if (rr_mode == 1) row_ready = 1'($urandom_range(0, 1));
      else row_ready = 1'b0;
    end
  end

  task automatic model(input int p[$], output int esum,
                       output int ens, output bit einc,
                       output logic [39:0] erows[$]);
    int tr[$];
    int x;
    logic [39:0] r;
    x = 1;
    foreach (p[i]) begin
      tr.push_back(x);
      if (p[i] != 0) begin
        tr.push_back(x);
        x += p[i];
      end
    end
    esum = 0; ens = 0;
    for (int k = 0; k < 6; k++) begin
      int c;
      c = 20 + 40 * k;
      if (c <= tr.size()) begin
        esum += tr[c-1] * c;
        ens++;
      end
    end
    einc = (ens < 6);
    erows.delete();
    r = '0;
    for (int c = 1; c <= tr.size(); c++) begin
      int col;
      col = (c - 1) % 40;
      if (tr[c-1] - 1 <= col && col <= tr[c-1] + 1) r[39-col] = 1'b1;
      if (col == 39 || c == tr.size()) begin
        erows.push_back(r);
        r = '0;
      end
    end
  endtask

  task automatic pulse_start();
    rows_q.delete();
    lasts_q.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done || err) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({proc_reset, cpu_en, busy, done, err, incomplete} !== 6'b100000) begin
      $display("FAIL reset_ctrl got %b want 100000",
               {proc_reset, cpu_en, busy, done, err, incomplete});
    end else passed++;
    total++;
    if ({sum_out, samples_taken, row_valid, row_last} !== 37'd0 ||
        row_data !== 40'd0) begin
      $display("FAIL reset_data sum %h samp %0d rv %b data %h",
               sum_out, samples_taken, row_valid, row_data);
    end else passed++;
  endtask

  task automatic test_standard();
    bit ok;
    int es, en;
    bit ei;
    logic [39:0] er[$];
    prog = std_prog;
    rr_mode = 0;
    model(prog, es, en, ei, er);
    pulse_start();
    wait_end(ok);
    total++;
    if (!ok || done !== 1'b1) $display("FAIL std_done got %b want 1", done);
    else passed++;
    total++;
    if (sum_out !== 32'd13140) $display("FAIL std_sum got %0d want 13140", sum_out);
    else passed++;
    total++;
    if (samples_taken !== 3'd6 || incomplete !== 1'b0)
      $display("FAIL std_samp got %0d/%b want 6/0", samples_taken, incomplete);
    else passed++;
    total++;
    if (rows_q.size() != 6) $display("FAIL std_rows got %0d want 6", rows_q.size());
    else passed++;
    total++;
    if (rows_q.size() < 1 || rows_q[0] !== 40'hCCCCCCCCCC)
      $display("FAIL std_row0 got %h want cccccccccc",
               rows_q.size() > 0 ? rows_q[0] : 40'hx);
    else passed++;
    for (int i = 0; i < er.size() && i < rows_q.size(); i++) begin
      total++;
      if (rows_q[i] !== er[i] || lasts_q[i] !== (i == er.size() - 1))
        $display("FAIL std_row%0d got %h/%b want %h/%b", i, rows_q[i],
                 lasts_q[i], er[i], i == er.size() - 1);
      else passed++;
    end
    total++;
    if (cpu_en !== 1'b0 || proc_reset !== 1'b0 || busy !== 1'b0)
      $display("FAIL std_idle cpu_en %b proc_reset %b busy %b",
               cpu_en, proc_reset, busy);
    else passed++;
  endtask

  task automatic test_stall();
    bit ok, seen;
    prog = std_prog;
    rr_mode = 2;
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (busy && !proc_reset && !cpu_en) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || cycles_in !== 16'd80)
      $display("FAIL stall_at got %0d want 80 (seen %b)", cycles_in, seen);
    else passed++;
    total++;
    if (row_valid !== 1'b1 || row_data !== 40'hCCCCCCCCCC)
      $display("FAIL stall_row got %b/%h want 1/cccccccccc", row_valid, row_data);
    else passed++;
    repeat (10) @(negedge clk);
    total++;
    if (cycles_in !== 16'd80 || cpu_en !== 1'b0)
      $display("FAIL stall_hold got %0d/%b want 80/0", cycles_in, cpu_en);
    else passed++;
    rr_mode = 0;
    wait_end(ok);
    total++;
    if (!ok || done !== 1'b1 || sum_out !== 32'd13140 || rows_q.size() != 6)
      $display("FAIL stall_end got done %b sum %0d rows %0d want 1 13140 6",
               done, sum_out, rows_q.size());
    else passed++;
  endtask

  task automatic test_term_first();
    bit ok;
    prog.delete();
    rr_mode = 1;
    pulse_start();
    wait_end(ok);
    total++;
    if (!ok || done !== 1'b1 || incomplete !== 1'b1)
      $display("FAIL term0_done got %b/%b want 1/1", done, incomplete);
    else passed++;
    total++;
    if (sum_out !== 32'd0 || samples_taken !== 3'd0 || rows_q.size() != 0)
      $display("FAIL term0_out got sum %h samp %0d rows %0d want 0 0 0",
               sum_out, samples_taken, rows_q.size());
    else passed++;
  endtask

  task automatic test_partial();
    bit ok;
    int es, en;
    bit ei;
    logic [39:0] er[$];
    prog.delete();
    prog.push_back(-4);
    repeat (23) prog.push_back(0);
    rr_mode = 1;
    model(prog, es, en, ei, er);
    pulse_start();
    wait_end(ok);
    total++;
    if (!ok || sum_out !== 32'hFFFFFFC4 || samples_taken !== 3'd1)
      $display("FAIL part_sum got %h/%0d want ffffffc4/1", sum_out, samples_taken);
    else passed++;
    total++;
    if (incomplete !== 1'b1) $display("FAIL part_inc got %b want 1", incomplete);
    else passed++;
    total++;
    if (rows_q.size() != 1 || rows_q[0] !== 40'hC000000000 ||
        rows_q[0] !== er[0] || lasts_q[0] !== 1'b1)
      $display("FAIL part_row got n %0d row %h want 1 c000000000 last",
               rows_q.size(), rows_q.size() > 0 ? rows_q[0] : 40'hx);
    else passed++;
  endtask

  task automatic test_err();
    bit ok;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (err_b || done_b) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || err_b !== 1'b1 || done_b !== 1'b0)
      $display("FAIL err_flag got err %b done %b want 1 0", err_b, done_b);
    else passed++;
    total++;
    if (last_b !== 16'd100 || cpu_en_b !== 1'b0 || busy_b !== 1'b0)
      $display("FAIL err_stop got cyc %0d cpu_en %b busy %b want 100 0 0",
               last_b, cpu_en_b, busy_b);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    bit ok, hit;
    prog = std_prog;
    rr_mode = 1;
    pulse_start();
    hit = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (cycles_in == 16'd50 && busy && !proc_reset) begin hit = 1'b1; break; end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (!hit || {proc_reset, cpu_en, busy, done, incomplete} !== 5'b10000 ||
        sum_out !== 32'd0 || samples_taken !== 3'd0 ||
        row_valid !== 1'b0 || row_data !== 40'd0 || row_last !== 1'b0)
      $display("FAIL midreset got pr %b en %b busy %b sum %h rv %b (hit %b)",
               proc_reset, cpu_en, busy, sum_out, row_valid, hit);
    else passed++;
    reset = 1'b0;
    pulse_start();
    wait_end(ok);
    total++;
    if (!ok || sum_out !== 32'd13140 || rows_q.size() != 6)
      $display("FAIL midreset_rerun got sum %0d rows %0d want 13140 6",
               sum_out, rows_q.size());
    else passed++;
  endtask

  task automatic test_random();
    bit ok;
    int es, en;
    bit ei;
    logic [39:0] er[$];
    for (int it = 0; it < 10; it++) begin
      int n;
      prog.delete();
      n = $urandom_range(1, 70);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          int v;
          v = int'($urandom_range(0, 10)) - 5;
          if (v == 0) v = 3;
          prog.push_back(v);
        end else prog.push_back(0);
      end
      rr_mode = 1;
      model(prog, es, en, ei, er);
      pulse_start();
      wait_end(ok);
      total++;
      if (!ok || done !== 1'b1 || sum_out !== 32'(es) ||
          samples_taken !== 3'(en) || incomplete !== ei)
        $display("FAIL rnd%0d_sum got %0d/%0d/%b want %0d/%0d/%b", it,
                 $signed(sum_out), samples_taken, incomplete, es, en, ei);
      else passed++;
      total++;
      if (rows_q.size() != er.size())
        $display("FAIL rnd%0d_nrows got %0d want %0d", it, rows_q.size(), er.size());
      else passed++;
      for (int i = 0; i < er.size() && i < rows_q.size(); i++) begin
        total++;
        if (rows_q[i] !== er[i] || lasts_q[i] !== (i == er.size() - 1))
          $display("FAIL rnd%0d_row%0d got %h/%b want %h/%b", it, i,
                   rows_q[i], lasts_q[i], er[i], i == er.size() - 1);
        else passed++;
      end
    end
  endtask

  initial begin
    std_prog = {15, -11, 6, -3, 5, -1, -8, 13, 4, 0,
                -1, 5, -1, 5, -1, 5, -1, 5, -1, -35,
                1, 24, -19, 1, 16, -11, 0, 0, 21, -15,
                0, 0, -3, 9, 1, -3, 8, 1, 5, 0,
                0, 0, 0, 0, -36, 0, 1, 7, 0, 0,
                0, 2, 6, 0, 0, 0, 0, 0, 1, 0,
                0, 7, 1, 0, -13, 13, 7, 0, 1, -33,
                0, 0, 0, 2, 0, 0, 0, 8, 0, -1,
                2, 1, 0, 17, -9, 1, 1, -3, 11, 0,
                0, 1, 0, 1, 0, 0, -13, -19, 1, 3,
                26, -30, 12, -1, 3, 1, 0, 0, 0, -9,
                18, 1, 2, 0, 0, 9, 0, 0, 0, -1,
                2, -37, 1, 3, 0, 15, -21, 22, -6, 1,
                0, 2, 1, 0, -10, 0, 0, 20, 1, 2,
                2, -6, -11, 0, 0, 0};
    reset = 1'b1;
    start = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1 reset = 1'b0;
    test_standard();
    test_stall();
    test_term_first();
    test_partial();
    test_err();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/signal_run_ctrl.md
Name: signal_run_ctrl

Overview:
Run controller for the signal processor core. Resets the core, single-steps it through a clock enable, and accumulates signal strength at scheduled cycles. Also renders the 40-column CRT image row by row over a valid/ready stream, stalling the core under backpressure. Sits between the system top (start/done) and the signal processor plus row-consumer logic.

Parameters:
FIRST_SAMPLE, 20, cycle number of the first signal-strength sample
SAMPLE_STEP, 40, cycle distance between samples
NUM_SAMPLES, 6, number of samples summed
ROW_WIDTH, 40, CRT pixels per row
MAX_CYCLES, 16'hFFFF, cycle count at which a run without TERM is aborted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: begin a run (sampled in IDLE/DONE/ERR only)
proc_reset  out  1  drives the processor's reset
cpu_en  out  1  processor clock enable; core advances one cycle per clk while high
cycles_in  in  16  processor cycle counter (current cycle number)
x_in  in  16  processor X register, signed, value during current cycle
term_in  in  1  processor TERM opcode decoded
busy  out  1  run in progress
done  out  1  run finished normally; held until next start
err  out  1  MAX_CYCLES reached without TERM; held until next start
incomplete  out  1  TERM seen before NUM_SAMPLES samples taken
sum_out  out  32  signed sum of sampled signal strengths
samples_taken  out  3  samples accumulated so far
row_valid  out  1  row_data holds a completed CRT row
row_ready  in  1  consumer accepts row when high with row_valid
row_data  out  ROW_WIDTH  bit ROW_WIDTH-1 = column 0; 1 = lit
row_last  out  1  qualifies row_data as final row of run

Behaviour:
- Reset: state IDLE; proc_reset=1, cpu_en=0, busy=done=err=incomplete=0, sum_out=0, samples_taken=0, row_valid=0, row_data=0, row_last=0, column counter 0.
- FSM IDLE -> CLEAR on start. CLEAR (1 cycle): proc_reset=1, clear sum, samples, column, row shift register; -> RUN. start in RUN/STALL/CLEAR ignored.
- RUN: proc_reset=0, busy=1. cpu_en = 1 except STALL condition. A "step" is any clk with cpu_en=1; the block uses cycles_in/x_in presented at that edge.
- Step with term_in=1: no sample, no pixel; cpu_en drops next cycle; -> FLUSH. incomplete=1 if samples_taken<NUM_SAMPLES.
- Step with term_in=0, cycles_in==MAX_CYCLES: -> ERR (err=1, busy=0, cpu_en=0, rows discarded).
- Sampling: on step where cycles_in == FIRST_SAMPLE + k*SAMPLE_STEP, k<NUM_SAMPLES: sum_out += signed(x_in) * {0,cycles_in}; 32-bit signed, wraps modulo 2^32; samples_taken+1. Updated value visible cycle after the step.
- Pixel: on step, lit = (x_in-1 <= col <= x_in+1), 17-bit signed compare, col 0..ROW_WIDTH-1; shifted in; col increments, wraps to 0 after ROW_WIDTH-1.
- Row emit: step at col==ROW_WIDTH-1 copies shift register into row_data, row_valid=1 next cycle. row_valid/row_data stable until row_valid&row_ready; then row_valid=0 unless a new row loads same cycle.
- STALL: in RUN, col==ROW_WIDTH-1, row_valid=1, row_ready=0 -> cpu_en=0 (combinational). Core frozen; resumes the cycle row_ready rises.
- FLUSH: if col!=0, partial row emitted, unfilled bits 0, once row_data is free. Final emitted row has row_last=1. If the run emitted no row, skip to DONE. -> DONE after row_last row accepted.
- DONE: busy=0, done=1, cpu_en=0, proc_reset=0 (core outputs stay inspectable). start -> CLEAR (clears done/err/incomplete).
- Reset mid-run: asynchronous return to reset values; pending row lost.

Decomposition:
- Package signal_pkg: FSM state enum (IDLE, CLEAR, RUN, FLUSH, DONE, ERR), opcode constants (NOOP, ADDX, TERM) shared with processor, default ROW_WIDTH.
- Sub-module crt_row_buffer: column counter, pixel compare, shift register, valid/ready output register, stall signal.

Test Plan:
- Standard 146-instruction example ROM, row_ready=1 -> sum_out=13140, samples_taken=6, 6 rows, row 0 = ##..##..##..##..##..##..##..##..##..##.., row 5 row_last=1, done=1, incomplete=0.
- Same ROM, row_ready low from row 0 until cycle 90 -> cpu_en drops when cycles_in=80; cycles_in held; resumes when row_ready=1; final sum 13140 unchanged.
- ROM with TERM at pc 0 -> done after 1 step, sum_out=0, samples_taken=0, incomplete=1, no row emitted.
- addx -4 then noops, TERM after cycle 25 -> sample at 20 = -60 (sum_out=32'hFFFFFFC4); partial 25-pixel row emitted with row_last=1; incomplete=1.
- MAX_CYCLES=100, 200 noops, no TERM -> err=1 at cycles_in=100, done=0, cpu_en=0.
- Assert reset at cycle 50 of a run -> all outputs at reset values next cycle, proc_reset=1; subsequent start reproduces 13140.
